// File: rtl/vga_vtgen.sv
// VGA video timing generator: line/frame counters, sync/gate/blank decode, registered outputs.
// Interlaced field support is built only when VGA_VTGEN_INTERLACE_EN is defined.
module vga_vtgen #(
    parameter int HW = 16,
    parameter int VW = 16,
    parameter int SW = 8
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic          ena_i,
    input  logic          hpol_i,
    input  logic          vpol_i,
    input  logic          cpol_i,
    input  logic          bpol_i,
    input  logic [SW-1:0] thsync_i,
    input  logic [SW-1:0] thgdel_i,
    input  logic [HW-1:0] thgate_i,
    input  logic [HW-1:0] thlen_i,
    input  logic [SW-1:0] tvsync_i,
    input  logic [SW-1:0] tvgdel_i,
    input  logic [VW-1:0] tvgate_i,
    input  logic [VW-1:0] tvlen_i,
    input  logic          interlace_i,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          csync_o,
    output logic          blank_o,
    output logic          gate_o,
    output logic          eoh_o,
    output logic          eov_o,
    output logic          field_o,
    output logic [HW-1:0] hcnt_o,
    output logic [VW-1:0] vcnt_o
);

    // Window bounds are sums of several fields; widen so they never overflow.
    localparam int HXW = ((HW > SW) ? HW : SW) + 2;
    localparam int VXW = ((VW > SW) ? VW : SW) + 2;

    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [VW-1:0]  vcnt_q, vcnt_d;

    logic [HXW-1:0] hpos, hsync_last, hgate_first, hgate_last;
    logic [VXW-1:0] vpos, vsync_last, vgate_first, vgate_last;
    logic [VW:0]    vlast;
    logic           odd_field;
    logic           hsync_raw, vsync_raw, hgate_raw, vgate_raw, gate_raw;
    logic           eol, eof;

    assign hpos        = HXW'(hcnt_q);
    assign hsync_last  = HXW'(thsync_i);
    assign hgate_first = HXW'(thsync_i) + HXW'(thgdel_i) + HXW'(2);
    assign hgate_last  = hgate_first + HXW'(thgate_i);

    assign vpos        = VXW'(vcnt_q);
    assign vsync_last  = VXW'(tvsync_i);
    assign vgate_first = VXW'(tvsync_i) + VXW'(tvgdel_i) + VXW'(2);
    assign vgate_last  = vgate_first + VXW'(tvgate_i);

`ifdef VGA_VTGEN_INTERLACE_EN
    logic        field_q, field_d;
    logic [HW:0] hhalf;
    logic        past_half;

    assign odd_field = interlace_i & field_q;
    assign hhalf     = ({1'b0, thlen_i} + (HW+1)'(1)) >> 1;
    assign past_half = ({1'b0, hcnt_q} >= hhalf);
`else
    logic unused_interlace;

    assign odd_field        = 1'b0;
    assign unused_interlace = interlace_i;
`endif

    // The odd field carries one extra line.
    assign vlast = {1'b0, tvlen_i} + (VW+1)'(odd_field);

    // Counters never exceed their limit, so windows past the wrap are truncated for free.
    assign hsync_raw = (hpos <= hsync_last);
    assign hgate_raw = (hpos >= hgate_first) && (hpos <= hgate_last);
    assign vgate_raw = (vpos >= vgate_first) && (vpos <= vgate_last);
    assign gate_raw  = hgate_raw & vgate_raw;

    assign eol = (hcnt_q == thlen_i);
    assign eof = eol && ({1'b0, vcnt_q} == vlast);

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
        vsync_raw = (vpos <= vsync_last);
`ifdef VGA_VTGEN_INTERLACE_EN
        // Odd field: vsync edges move to mid-line.
        if (odd_field) begin
            vsync_raw = ((vcnt_q == '0) && past_half)
                     || ((vpos >= VXW'(1)) && (vpos <= vsync_last))
                     || ((vpos == vsync_last + VXW'(1)) && !past_half);
        end
`endif
    end

    always_comb begin
        hcnt_d = (hcnt_q >= thlen_i) ? '0 : hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if ({1'b0, vcnt_q} > vlast) begin
            vcnt_d = '0;
        end else if (eol) begin
            vcnt_d = eof ? '0 : vcnt_q + VW'(1);
        end
        if (!ena_i) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Disabled: raw syncs inactive and gate low, so blank lands at its active level.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            csync_o <= 1'b0;
            blank_o <= 1'b0;
            gate_o  <= 1'b0;
            eoh_o   <= 1'b0;
            eov_o   <= 1'b0;
            hcnt_o  <= '0;
            vcnt_o  <= '0;
        end else begin
            hsync_o <= (ena_i & hsync_raw) ^ hpol_i;
            vsync_o <= (ena_i & vsync_raw) ^ vpol_i;
            csync_o <= (ena_i & (hsync_raw | vsync_raw)) ^ cpol_i;
            blank_o <= ~(ena_i & gate_raw) ^ bpol_i;
            gate_o  <= ena_i & gate_raw;
            eoh_o   <= ena_i & eol;
            eov_o   <= ena_i & eof;
            hcnt_o  <= ena_i ? hcnt_q : '0;
            vcnt_o  <= ena_i ? vcnt_q : '0;
        end
    end

`ifdef VGA_VTGEN_INTERLACE_EN
    always_comb begin
        field_d = field_q;
        if (!ena_i || !interlace_i) begin
            field_d = 1'b0;
        end else if (eof) begin
            field_d = ~field_q;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            field_q <= 1'b0;
            field_o <= 1'b0;
        end else begin
            field_q <= field_d;
            field_o <= ena_i & field_q;
        end
    end
`else
    assign field_o = 1'b0;
`endif

endmodule
